// File: rtl/bvb_loader.sv
// rtl/bvb_loader.sv - banked vector buffer writer: packs values into ping-pong image slots
module bvb_loader #(
  parameter int val_bits      = 8,
  parameter int ram_width     = 256,
  parameter int ram_splits    = 16,
  parameter int bvb_addr_size = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [val_bits-1:0]      val,
  input  logic                     val_fifo_empty,
  output logic                     val_fifo_read,
  output logic                     ram_we,
  output logic [bvb_addr_size:0]   ram_addr,
  output logic [ram_width-1:0]     ram_din,
  output logic [bvb_addr_size:0]   image_start,
  output logic                     image_valid,
  input  logic                     image_release
);

  localparam int vpw    = ram_width / val_bits;
  localparam int lane_w = (vpw > 1) ? $clog2(vpw) : 1;
  localparam int word_w = (ram_splits > 1) ? $clog2(ram_splits) : 1;
  localparam int aw     = bvb_addr_size + 1;

  localparam logic [lane_w-1:0] last_lane  = lane_w'(vpw - 1);
  localparam logic [word_w-1:0] last_word  = word_w'(ram_splits - 1);
  localparam logic [aw-1:0]     slot1_base = aw'(ram_splits);

  typedef enum logic {FILL, WAIT_REL} state_t;

  state_t               state, state_nx;
  logic [lane_w-1:0]    lane;
  logic [word_w-1:0]    word;
  logic                 fill_slot;
  logic [ram_width-1:0] pack, pack_nx;
  logic                 img_pend;     // the ram_we now on the bus is the last word of an image
  logic                 accept;
  logic                 word_done;
  logic                 publish;
  logic [aw-1:0]        slot_base;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_nx;
  end

  // Next state: stall after an image when the reader still owns the other slot
  always_comb begin
    state_nx = state;
    case (state)
      FILL:     if (img_pend && image_valid && !image_release) state_nx = WAIT_REL;
      WAIT_REL: if (image_release) state_nx = FILL;
      default:  state_nx = FILL;
    endcase
  end

  // Outputs of the FSM: pop whenever filling and data is present
  always_comb begin
    val_fifo_read = rst && (state == FILL) && !val_fifo_empty;
  end

  // Handshake decodes shared by the datapath and image bookkeeping
  always_comb begin
    accept    = val_fifo_read;
    word_done = accept && (lane == last_lane);
    slot_base = fill_slot ? slot1_base : '0;
    publish   = ((state == FILL) && img_pend && (!image_valid || image_release)) ||
                ((state == WAIT_REL) && image_release);
  end

  // Pack word with the value accepted this cycle merged in
  always_comb begin
    pack_nx = pack;
    if (accept) pack_nx[lane*val_bits +: val_bits] = val;
  end

  // Packing datapath and RAM write port; next word packs while this one is written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane     <= '0;
      word     <= '0;
      pack     <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      img_pend <= 1'b0;
    end else begin
      pack     <= pack_nx;
      ram_we   <= word_done;
      img_pend <= word_done && (word == last_word);
      if (accept) lane <= word_done ? '0 : lane + 1'b1;
      if (word_done) begin
        ram_din  <= pack_nx;
        ram_addr <= slot_base + aw'(word);
        word     <= (word == last_word) ? '0 : word + 1'b1;
      end
    end
  end

  // Image ownership: publish completed slot, swap slots, or drop ownership on release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      image_start <= '0;
      image_valid <= 1'b0;
      fill_slot   <= 1'b0;
    end else if (publish) begin
      image_start <= slot_base;
      image_valid <= 1'b1;
      fill_slot   <= ~fill_slot;
    end else if (image_release) begin
      image_valid <= 1'b0;
    end
  end

endmodule
